// File: rtl/int_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Latency: width edges from accept to done (1 edge for divide-by-zero); start ignored while busy.
module int_divider #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(width) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [width-1:0] dvd_q;
  logic [width-1:0] dvs_q;
  logic [width:0]   prem_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             dbz_now;
  logic             last;
  logic [width:0]   shifted;
  logic [width:0]   trial;
  logic [width:0]   prem_nxt;
  logic [width-1:0] dvd_nxt;

  assign accept  = start && (state != RUN);
  assign dbz_now = (state == RUN) && (dvs_q == '0);
  assign last    = (state == RUN) && (cnt_q == CW'(width - 1));
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  // The dividend register doubles as the quotient accumulator: bits shift out
  // into the partial remainder at the top while quotient bits enter at the bottom.
  always_comb begin
    shifted  = {prem_q[width-1:0], dvd_q[width-1]};
    trial    = shifted - {1'b0, dvs_q};
    prem_nxt = shifted;
    dvd_nxt  = {dvd_q[width-2:0], 1'b0};
    if (!trial[width]) begin
      prem_nxt = trial;
      dvd_nxt  = {dvd_q[width-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (dbz_now || last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_q       <= dividend;
      dvs_q       <= divisor;
      prem_q      <= '0;
      cnt_q       <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      if (dbz_now) begin
        // dvd_q is still the untouched captured dividend on the first RUN edge
        quotient    <= '1;
        remainder   <= dvd_q;
        div_by_zero <= 1'b1;
      end else begin
        prem_q <= prem_nxt;
        dvd_q  <= dvd_nxt;
        cnt_q  <= cnt_q + CW'(1);
        if (last) begin
          quotient  <= dvd_nxt;
          remainder <= prem_nxt[width-1:0];
        end
      end
    end
  end

endmodule
